// File: rtl/instr_fetch_queue_if.sv
// rtl/instr_fetch_queue_if.sv - fetch-queue bus bundle: instruction-memory, redirect and decode handshakes
//
// Purpose: groups every non-clock signal of instr_fetch_queue so the block can be
// connected with one interface port.
//   master modport : seen by the fetch queue
//   slave modport  : seen by memory / execute / decode
// Signals:
//   imem_req, imem_addr        request to instruction memory (held until imem_ack)
//   imem_ack, imem_rdata       memory response
//   redirect, redirect_target  taken branch/jump from execute
//   instr_valid, instr_ready   head-of-queue handshake with decode
//   instr, instr_pc            head word and its PC
//   count                      entries queued

interface instr_fetch_queue_if #(
  parameter int DATA_WIDTH    = 20,
  parameter int ADDRESS_WIDTH = 8,
  parameter int FIFO_DEPTH    = 4
);
  localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

  logic                     imem_req;
  logic [ADDRESS_WIDTH-1:0] imem_addr;
  logic                     imem_ack;
  logic [DATA_WIDTH-1:0]    imem_rdata;
  logic                     redirect;
  logic [ADDRESS_WIDTH-1:0] redirect_target;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [DATA_WIDTH-1:0]    instr;
  logic [ADDRESS_WIDTH-1:0] instr_pc;
  logic [COUNT_WIDTH-1:0]   count;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, count,
    input  imem_ack, imem_rdata, redirect, redirect_target, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, count,
    output imem_ack, imem_rdata, redirect, redirect_target, instr_ready
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction-fetch front end with PC, memory handshake and decode FIFO
//
// Purpose: owns the fetch PC, issues req/ack fetches to instruction memory, queues
// fetched words with their PCs and presents the queue head to decode. A redirect
// flushes the queue and restarts fetch at the new target.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-low reset
//   bus  instr_fetch_queue_if.master (memory, redirect and decode handshakes, count)

module instr_fetch_queue #(
  parameter int                     DATA_WIDTH    = 20,
  parameter int                     ADDRESS_WIDTH = 8,
  parameter int                     FIFO_DEPTH    = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0
) (
  input logic                  clk,
  input logic                  rst,
  instr_fetch_queue_if.master  bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [ADDRESS_WIDTH-1:0] r_fetch_pc;
  logic [ADDRESS_WIDTH-1:0] w_fetch_pc_next;
  logic [ADDRESS_WIDTH-1:0] r_imem_addr;
  logic [ADDRESS_WIDTH-1:0] w_imem_addr_next;
  logic [CW-1:0]            r_count;
  logic [CW-1:0]            w_count_next;
  logic [CW-1:0]            w_count_after_pop;
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [PW-1:0]            w_wr_ptr_next;
  logic [PW-1:0]            w_rd_ptr_next;
  logic                     w_push;
  logic                     w_pop;

  logic [DATA_WIDTH-1:0]    r_fifo_data [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];

  // A pop in the redirect cycle is void: the flush wins and decode squashes it.
  assign w_pop             = (r_count != '0) && bus.instr_ready && !bus.redirect;
  assign w_count_after_pop = r_count - CW'(w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_imem_addr <= RESET_PC;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_fetch_pc  <= w_fetch_pc_next;
      r_imem_addr <= w_imem_addr_next;
      r_count     <= w_count_next;
      r_wr_ptr    <= w_wr_ptr_next;
      r_rd_ptr    <= w_rd_ptr_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_fetch_pc_next  = r_fetch_pc;
    w_imem_addr_next = r_imem_addr;
    w_push           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Issue only if the entry being fetched is guaranteed a slot.
        if (!bus.redirect && (w_count_after_pop < DEPTH_C)) begin
          w_state_next     = ST_WAIT;
          w_imem_addr_next = r_fetch_pc;
        end
      end

      ST_WAIT: begin
        if (bus.redirect) begin
          // An ack arriving with the redirect completes the old request; otherwise
          // the stale response still has to be absorbed in DISCARD.
          w_state_next = bus.imem_ack ? ST_IDLE : ST_DISCARD;
        end else if (bus.imem_ack) begin
          w_push          = 1'b1;
          w_fetch_pc_next = r_fetch_pc + 1'b1;
          if ((w_count_after_pop + CW'(1)) < DEPTH_C) begin
            w_imem_addr_next = r_fetch_pc + 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end

      ST_DISCARD: begin
        // The address stays on the old request; its response is dropped.
        if (bus.imem_ack) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (bus.redirect) begin
      w_fetch_pc_next = bus.redirect_target;
    end
  end

  always_comb begin
    w_count_next  = w_count_after_pop + CW'(w_push);
    w_wr_ptr_next = r_wr_ptr + PW'(w_push);
    w_rd_ptr_next = r_rd_ptr + PW'(w_pop);
    if (bus.redirect) begin
      w_count_next  = '0;
      w_wr_ptr_next = '0;
      w_rd_ptr_next = '0;
    end
  end

  // Queue storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= bus.imem_rdata;
      r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
    end
  end

  assign bus.imem_req    = (r_state != ST_IDLE);
  assign bus.imem_addr   = r_imem_addr;
  assign bus.instr_valid = (r_count != '0);
  assign bus.instr       = r_fifo_data[r_rd_ptr];
  assign bus.instr_pc    = r_fifo_pc[r_rd_ptr];
  assign bus.count       = r_count;

endmodule
